// File: rtl/pc_redirect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_pkg
// Description : Shared types and constants for the PC redirect unit:
//               FSM state encoding, redirect-cause trace encoding, default
//               PC width / reset PC, bubble timer width and a saturating
//               16-bit increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_redirect_pkg;

    localparam int          c_default_pc_w     = 16;
    localparam logic [15:0] c_default_reset_pc = 16'h0000;
    localparam int          c_timer_w          = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // Why the PC left the sequential path; kept for trace/debug visibility.
    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_BRANCH = 2'd1,
        CAUSE_JUMP   = 2'd2
    } cause_t;

    // Jumps take precedence in the trace encoding when both enables are set.
    function automatic cause_t redirect_cause(input logic resolve_valid,
                                              input logic branch_en,
                                              input logic jump_en);
        cause_t w_c;
        w_c = CAUSE_NONE;
        if (resolve_valid) begin
            if (jump_en)        w_c = CAUSE_JUMP;
            else if (branch_en) w_c = CAUSE_BRANCH;
        end
        return w_c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage : pc_redirect_pkg
`default_nettype wire

// File: rtl/pc_redirect_unit_flush_timer.sv
`default_nettype none
// ============================================================================
// Module      : flush_timer
// Description : 3-bit loadable down-counter timing the fetch bubble after a
//               redirect. Load has priority over decrement; decrement stops
//               at zero.
// Ports       : clk, rst (async, active-high)
//               i_load / i_load_val : load the counter
//               i_dec               : decrement by one (floors at zero)
//               o_count             : current count
//               o_zero              : count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module flush_timer
    import pc_redirect_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [c_timer_w-1:0] i_load_val,
    input  logic                 i_dec,
    output logic [c_timer_w-1:0] o_count,
    output logic                 o_zero
);

    logic [c_timer_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_timer_w'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule : flush_timer
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Owns the architectural fetch PC. Static predict-not-taken:
//               every resolved taken branch/jump redirects the PC, pulses
//               the IF/ID and ID/EX flushes for one cycle and inserts
//               FLUSH_CYCLES fetch bubbles. A decoded HALT freezes the PC
//               until reset.
// Config      : `define BRANCH_STATS_EN builds the saturating resolve and
//               redirect counters; otherwise br_count/redir_count read 0.
// Ports       : clk, rst (async, active-high)
//               stall, imem_ready, halt_dec       : pipeline status
//               resolve_valid, branch_en, jump_en,
//               target_pc                         : execute-stage resolution
//               pc_out, pc_plus2, fetch_valid     : fetch interface
//               flush_if_id, flush_id_ex          : squash strobes
//               halted, misalign_err              : sticky status
//               br_count, redir_count             : optional statistics
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit
    import pc_redirect_pkg::*;
#(
    parameter int              PC_W         = c_default_pc_w,
    parameter logic [PC_W-1:0] RESET_PC     = PC_W'(c_default_reset_pc),
    parameter int              FLUSH_CYCLES = 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            halt_dec,
    input  logic            resolve_valid,
    input  logic            branch_en,
    input  logic            jump_en,
    input  logic [PC_W-1:0] target_pc,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus2,
    output logic            fetch_valid,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            halted,
    output logic            misalign_err,
    output logic [15:0]     br_count,
    output logic [15:0]     redir_count
);

    localparam logic [c_timer_w-1:0] c_flush_load = c_timer_w'(FLUSH_CYCLES);

    state_t                 r_state, w_state_next;
    logic [PC_W-1:0]        r_pc, w_pc_next;
    logic                   r_flush, w_flush_next;
    logic                   r_misalign, w_misalign_next;

    logic                   w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic [c_timer_w-1:0]   w_tmr_count;

    cause_t                 w_cause;
    logic                   w_redirect;
    logic                   w_take_redirect;
    logic                   w_run_go;
    logic                   w_bubble_last;
    logic [PC_W-1:0]        w_pc_plus2;

    assign w_cause         = redirect_cause(resolve_valid, branch_en, jump_en);
    assign w_redirect      = (w_cause != CAUSE_NONE);
    // HALT is terminal: a redirect resolving after it must not move the PC.
    assign w_take_redirect = w_redirect && (r_state != ST_HALT);
    assign w_run_go        = imem_ready && !stall;
    assign w_pc_plus2      = r_pc + PC_W'(2);
    // The bubble ends on the cycle whose decrement brings the timer to zero,
    // giving exactly FLUSH_CYCLES non-fetching cycles.
    assign w_bubble_last   = w_tmr_zero || (w_tmr_count == c_timer_w'(1));

    flush_timer u_flush_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (c_flush_load),
        .i_dec      (w_tmr_dec),
        .o_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_flush    <= w_flush_next;
            r_misalign <= w_misalign_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_flush_next    = 1'b0;
        w_misalign_next = r_misalign;
        w_tmr_load      = 1'b0;
        w_tmr_dec       = 1'b0;

        // An older control-flow instruction in EX overrides anything the
        // younger IF/ID side is asking for, including a decoded HALT.
        if (w_take_redirect) begin
            w_pc_next       = {target_pc[PC_W-1:1], 1'b0};
            w_flush_next    = 1'b1;
            w_tmr_load      = 1'b1;
            w_state_next    = ST_BUBBLE;
            w_misalign_next = r_misalign | target_pc[0];
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_run_go) begin
                        if (halt_dec) begin
                            w_state_next = ST_HALT;
                        end else begin
                            w_pc_next = w_pc_plus2;
                        end
                    end
                end
                ST_BUBBLE: begin
                    w_tmr_dec = 1'b1;
                    if (w_bubble_last) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    assign pc_out       = r_pc;
    assign pc_plus2     = w_pc_plus2;
    // Reset gating keeps fetch_valid low while reset is asserted even though
    // the reset state is RUN.
    assign fetch_valid  = !rst && (r_state == ST_RUN) && w_run_go;
    assign flush_if_id  = r_flush;
    assign flush_id_ex  = r_flush;
    assign halted       = (r_state == ST_HALT);
    assign misalign_err = r_misalign;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_br_count;
    logic [15:0] r_redir_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count    <= 16'h0000;
            r_redir_count <= 16'h0000;
        end else if (r_state != ST_HALT) begin
            if (resolve_valid) begin
                r_br_count <= sat_inc16(r_br_count);
            end
            if (w_redirect) begin
                r_redir_count <= sat_inc16(r_redir_count);
            end
        end
    end

    assign br_count    = r_br_count;
    assign redir_count = r_redir_count;
`else
    assign br_count    = 16'h0000;
    assign redir_count = 16'h0000;
`endif

endmodule : pc_redirect_unit
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_unit
// Description : Self-checking bench for pc_redirect_unit (FLUSH_CYCLES=2):
//               directed vector table, multi-cycle hand sequences (async
//               reset, statistics counters, PC wraparound) and a randomized
//               run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, imem_ready, halt_dec, resolve_valid, branch_en, jump_en;
    logic [15:0] target_pc;
    logic [15:0] pc_out, pc_plus2;
    logic        fetch_valid, flush_if_id, flush_id_ex, halted, misalign_err;
    logic [15:0] br_count, redir_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .PC_W         (16),
        .RESET_PC     (16'h0000),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .halt_dec      (halt_dec),
        .resolve_valid (resolve_valid),
        .branch_en     (branch_en),
        .jump_en       (jump_en),
        .target_pc     (target_pc),
        .pc_out        (pc_out),
        .pc_plus2      (pc_plus2),
        .fetch_valid   (fetch_valid),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .br_count      (br_count),
        .redir_count   (redir_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counters only exist when the statistics feature is built.
    function automatic logic [15:0] stat(input logic [15:0] v);
`ifdef BRANCH_STATS_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic drv(input logic s, input logic r, input logic h, input logic v,
                       input logic b, input logic j, input logic [15:0] t);
        @(negedge clk);
        stall = s; imem_ready = r; halt_dec = h;
        resolve_valid = v; branch_en = b; jump_en = j; target_pc = t;
    endtask

    typedef struct {
        logic        stall, rdy, halt, rv, br, jp;
        logic [15:0] tgt;
        logic [15:0] e_pc;
        logic        e_fv, e_fl, e_h, e_m;
    } vec_t;

    vec_t tbl[30];

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_pc;
    int          m_bub;      // remaining bubble cycles, 0 = fetching
    bit          m_halt, m_mis, m_fl;
    logic [15:0] m_br, m_rd;

    task automatic m_reset();
        m_pc = 16'h0000; m_bub = 0; m_halt = 0; m_mis = 0; m_fl = 0;
        m_br = 16'h0000; m_rd = 16'h0000;
    endtask

    task automatic m_step();
        bit taken;
        bit go;
        taken = resolve_valid && (branch_en || jump_en);
        go    = imem_ready && !stall;
        m_fl  = 0;
        if (!m_halt) begin
            if (resolve_valid && m_br != 16'hFFFF) m_br = m_br + 1;
            if (taken && m_rd != 16'hFFFF)         m_rd = m_rd + 1;
            if (taken) begin
                m_pc  = target_pc & 16'hFFFE;
                m_mis = m_mis | target_pc[0];
                m_fl  = 1;
                m_bub = FC;
            end else if (m_bub > 0) begin
                m_bub = m_bub - 1;
            end else if (go && halt_dec) begin
                m_halt = 1;
            end else if (go) begin
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    initial begin
        // stall rdy halt rv br jp  tgt      exp_pc   fv fl h  m
        tbl[0]  = '{0,1,0,0,0,0, 16'h0000, 16'h0000, 1,0,0,0};
        tbl[1]  = '{0,1,0,0,0,0, 16'h0000, 16'h0002, 1,0,0,0};
        tbl[2]  = '{0,1,0,0,0,0, 16'h0000, 16'h0004, 1,0,0,0};
        tbl[3]  = '{0,1,0,0,0,0, 16'h0000, 16'h0006, 1,0,0,0};
        tbl[4]  = '{0,1,0,0,0,0, 16'h0000, 16'h0008, 1,0,0,0};
        tbl[5]  = '{0,1,0,0,0,0, 16'h0000, 16'h000A, 1,0,0,0};
        tbl[6]  = '{0,1,0,0,0,0, 16'h0000, 16'h000C, 1,0,0,0};
        tbl[7]  = '{0,1,0,0,0,0, 16'h0000, 16'h000E, 1,0,0,0};
        tbl[8]  = '{0,1,0,1,1,0, 16'h0040, 16'h0010, 1,0,0,0};
        tbl[9]  = '{0,1,0,0,0,0, 16'h0000, 16'h0040, 0,1,0,0};
        tbl[10] = '{0,1,0,0,0,0, 16'h0000, 16'h0040, 0,0,0,0};
        tbl[11] = '{0,1,0,0,0,0, 16'h0000, 16'h0040, 1,0,0,0};
        tbl[12] = '{0,1,0,0,0,0, 16'h0000, 16'h0042, 1,0,0,0};
        tbl[13] = '{1,1,1,1,0,1, 16'h0100, 16'h0044, 0,0,0,0};
        tbl[14] = '{0,1,0,0,0,0, 16'h0000, 16'h0100, 0,1,0,0};
        tbl[15] = '{0,1,0,0,0,0, 16'h0000, 16'h0100, 0,0,0,0};
        tbl[16] = '{0,1,0,1,1,0, 16'h0033, 16'h0100, 1,0,0,0};
        tbl[17] = '{0,1,0,0,0,0, 16'h0000, 16'h0032, 0,1,0,1};
        tbl[18] = '{0,1,0,0,0,0, 16'h0000, 16'h0032, 0,0,0,1};
        tbl[19] = '{0,1,0,0,0,0, 16'h0000, 16'h0032, 1,0,0,1};
        tbl[20] = '{0,1,0,1,0,1, 16'h0200, 16'h0034, 1,0,0,1};
        tbl[21] = '{0,1,0,1,0,1, 16'h0300, 16'h0200, 0,1,0,1};
        tbl[22] = '{0,1,0,0,0,0, 16'h0000, 16'h0300, 0,1,0,1};
        tbl[23] = '{0,1,1,0,0,0, 16'h0000, 16'h0300, 0,0,0,1};
        tbl[24] = '{0,0,1,0,0,0, 16'h0000, 16'h0300, 0,0,0,1};
        tbl[25] = '{0,1,0,1,0,0, 16'h0500, 16'h0300, 1,0,0,1};
        tbl[26] = '{0,1,1,0,0,0, 16'h0000, 16'h0302, 1,0,0,1};
        tbl[27] = '{0,1,0,1,0,1, 16'h0080, 16'h0302, 0,0,1,1};
        tbl[28] = '{0,1,0,0,0,0, 16'h0000, 16'h0302, 0,0,1,1};
        tbl[29] = '{0,1,0,0,0,0, 16'h0000, 16'h0302, 0,0,1,1};

        // ---------------- reset state ----------------
        rst = 1'b1;
        stall = 0; imem_ready = 1; halt_dec = 0;
        resolve_valid = 0; branch_en = 0; jump_en = 0; target_pc = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc",       32'(pc_out),       32'h0000);
        check("rst_fv",       32'(fetch_valid),  32'h0);
        check("rst_flush",    32'({flush_if_id, flush_id_ex}), 32'h0);
        check("rst_halted",   32'(halted),       32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        check("rst_brcnt",    32'(br_count),     32'h0);
        check("rst_rdcnt",    32'(redir_count),  32'h0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 30; i++) begin
            drv(tbl[i].stall, tbl[i].rdy, tbl[i].halt, tbl[i].rv,
                tbl[i].br, tbl[i].jp, tbl[i].tgt);
            rst = 1'b0;
            #1;
            check($sformatf("tbl%0d_pc", i),     32'(pc_out),       32'(tbl[i].e_pc));
            check($sformatf("tbl%0d_pc2", i),    32'(pc_plus2),     32'(16'(tbl[i].e_pc + 16'd2)));
            check($sformatf("tbl%0d_fv", i),     32'(fetch_valid),  32'(tbl[i].e_fv));
            check($sformatf("tbl%0d_flif", i),   32'(flush_if_id),  32'(tbl[i].e_fl));
            check($sformatf("tbl%0d_flex", i),   32'(flush_id_ex),  32'(tbl[i].e_fl));
            check($sformatf("tbl%0d_halt", i),   32'(halted),       32'(tbl[i].e_h));
            check($sformatf("tbl%0d_mis", i),    32'(misalign_err), 32'(tbl[i].e_m));
        end

        // ---------------- async reset out of HALT ----------------
        drv(0, 1, 0, 0, 0, 0, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check("arst_pc",     32'(pc_out),       32'h0000);
        check("arst_halted", 32'(halted),       32'h0);
        check("arst_mis",    32'(misalign_err), 32'h0);
        check("arst_fv",     32'(fetch_valid),  32'h0);

        // ---------------- statistics: 3 resolves, 2 taken ----------------
        drv(0, 1, 0, 1, 1, 0, 16'h0010);
        rst = 1'b0;
        drv(0, 1, 0, 1, 0, 0, 16'h0000);
        drv(0, 1, 0, 1, 0, 1, 16'h0020);
        drv(0, 1, 0, 0, 0, 0, 16'h0000);
        #1;
        check("stat_pc",    32'(pc_out),      32'h0020);
        check("stat_brcnt", 32'(br_count),    32'(stat(16'd3)));
        check("stat_rdcnt", 32'(redir_count), 32'(stat(16'd2)));

        // ---------------- wraparound at 0xFFFE ----------------
        drv(0, 1, 0, 0, 0, 0, 16'h0000);
        rst = 1'b1;
        drv(0, 1, 0, 1, 0, 1, 16'hFFFE);
        rst = 1'b0;
        drv(0, 1, 0, 0, 0, 0, 16'h0000);
        drv(0, 1, 0, 0, 0, 0, 16'h0000);
        drv(0, 1, 0, 0, 0, 0, 16'h0000);
        #1;
        check("wrap_pc",  32'(pc_out),      32'hFFFE);
        check("wrap_pc2", 32'(pc_plus2),    32'h0000);
        check("wrap_fv",  32'(fetch_valid), 32'h1);
        drv(0, 1, 0, 0, 0, 0, 16'h0000);
        #1;
        check("wrap_next", 32'(pc_out), 32'h0000);

        // ---------------- randomized run vs reference model ----------------
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst           = (k == 0) || ($urandom_range(0, 79) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            imem_ready    = ($urandom_range(0, 4) != 0);
            halt_dec      = ($urandom_range(0, 79) == 0);
            resolve_valid = ($urandom_range(0, 2) == 0);
            branch_en     = 1'($urandom);
            jump_en       = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       target_pc = 16'hFFFE;
                1:       target_pc = 16'($urandom) | 16'h0001;
                default: target_pc = 16'($urandom) & 16'hFFFE;
            endcase
            #1;
            if (rst) m_reset();
            check("rnd_pc",    32'(pc_out),       32'(m_pc));
            check("rnd_pc2",   32'(pc_plus2),     32'(16'(m_pc + 16'd2)));
            check("rnd_fv",    32'(fetch_valid),
                  32'(!rst && !m_halt && m_bub == 0 && imem_ready && !stall));
            check("rnd_flif",  32'(flush_if_id),  32'(m_fl));
            check("rnd_flex",  32'(flush_id_ex),  32'(m_fl));
            check("rnd_halt",  32'(halted),       32'(m_halt));
            check("rnd_mis",   32'(misalign_err), 32'(m_mis));
            check("rnd_brcnt", 32'(br_count),     32'(stat(m_br)));
            check("rnd_rdcnt", 32'(redir_count),  32'(stat(m_rd)));
            if (!rst) m_step();
        end

        @(negedge clk);
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_redirect_unit
`default_nettype wire

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the architectural PC and the fetch-side response to branch and jump resolution.
- Consumes the branch-taken enable and target produced by the execute-stage branch condition logic, together with hazard stalls and decoded HALT.
- Drives the fetch PC, fetch-valid and the IF/ID and ID/EX flush strobes.
- Static predict-not-taken: every taken branch or jump is a redirect with a flush.

Parameters:
- PC_W, 16, PC and target width in bits.
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, fetch bubble cycles inserted after a redirect; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit stall; holds the PC.
- imem_ready  in  1  instruction memory can accept a fetch this cycle.
- halt_dec  in  1  HALT decoded in the ID stage.
- resolve_valid  in  1  execute stage holds a valid control-flow instruction.
- branch_en  in  1  conditional branch taken (from branch condition logic).
- jump_en  in  1  unconditional jump/JAL/JR.
- target_pc  in  PC_W  redirect target.
- pc_out  out  PC_W  current fetch PC.
- pc_plus2  out  PC_W  pc_out+2, wraps modulo 2^PC_W.
- fetch_valid  out  1  fetch at pc_out is real this cycle.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register.
- halted  out  1  processor halted (sticky).
- misalign_err  out  1  a redirect target had bit 0 set (sticky).
- br_count  out  16  resolved-branch count (feature only).
- redir_count  out  16  redirect count (feature only).

Behaviour:
- Reset (async, rst=1): pc_out=RESET_PC, state=RUN. fetch_valid, both flush outputs, halted, misalign_err, counters = 0.
- Reset mid-operation (any state) aborts that state immediately; operation resumes on the first clk edge after rst falls.
- Redirect definition: redirect = resolve_valid & (branch_en | jump_en).
- States: RUN, BUBBLE, HALT.
- RUN, fetch_valid = imem_ready & ~stall, evaluated in priority order:
  - redirect: next pc = {target_pc[PC_W-1:1],1'b0}. flush_if_id and flush_id_ex are registered high for exactly the next cycle. Load flush_timer with FLUSH_CYCLES and go to BUBBLE. Set misalign_err if target_pc[0]=1.
  - else halt_dec (only when imem_ready & ~stall): go to HALT with the PC held; halted=1 from the next cycle.
  - else stall or ~imem_ready: PC held.
  - else: PC <= pc_plus2.
- Redirect beats stall, halt_dec and ~imem_ready in the same cycle. The HALT in ID is younger than the branch in EX, so it is squashed.
- BUBBLE:
  - fetch_valid=0; PC held at target.
  - Timer decrements each cycle; on reaching 0, return to RUN.
  - A new redirect in BUBBLE reloads the PC and timer and pulses both flushes again.
  - halt_dec is ignored in BUBBLE.
- HALT:
  - fetch_valid=0, PC frozen, flushes 0.
  - Exit only by reset; redirect inputs are ignored.
- Flush outputs are 1-cycle pulses, never held. Back-to-back redirects produce back-to-back pulses.
- Wraparound: pc_out=16'hFFFE with no stall gives next pc_out=16'h0000.
- Outputs pc_out, pc_plus2 and fetch_valid are combinational from state registers only; no input-to-output paths except fetch_valid's dependence on stall and imem_ready.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - br_count increments on every resolve_valid cycle.
  - redir_count increments on every redirect.
  - Both are 16-bit and saturate at 16'hFFFF; both clear on reset.
  - Counting continues in BUBBLE; neither counter increments in HALT.
- Undefined: counter logic is not built; br_count and redir_count are driven constant 0. Ports remain present.

Decomposition:
- Package pc_redirect_pkg:
  - State enum {RUN, BUBBLE, HALT}.
  - Default RESET_PC and PC_W constants.
  - Redirect-cause encoding {NONE, BRANCH, JUMP}, for trace.
- Sub-module flush_timer: 3-bit loadable down-counter with load, dec and zero outputs, async active-high reset on rst. This is the single natural split.

Test Plan:
- Reset at RESET_PC=0, 4 idle cycles with imem_ready=1 -> pc_out 0,2,4,6; fetch_valid=1 throughout; no flushes.
- At pc=0x0010, resolve_valid=1, branch_en=1, target=0x0040, with FLUSH_CYCLES=2 -> next cycle pc_out=0x0040 and both flushes=1 for exactly 1 cycle; fetch_valid=0 for 2 cycles; then pc 0x0040,0x0042.
- Same cycle: stall=1, halt_dec=1, jump_en=1, target=0x0100 -> redirect wins, pc_out=0x0100, halted stays 0.
- halt_dec=1 with no redirect at pc=0x0020 -> halted=1 next cycle and pc frozen at 0x0020; a later redirect to 0x0080 is ignored; rst pulse gives pc_out=0 and halted=0.
- Target 0x0033 -> pc_out=0x0032 and misalign_err=1, sticky until reset. Separately, pc=0xFFFE with no stall -> next pc_out=0x0000.
- With BRANCH_STATS_EN: 3 resolves (2 taken) -> br_count=3, redir_count=2. Without the macro both read 0.
